dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder: the memory end of the pipeline's MEM-stage load/store interface. Accepts one request at a time from the CPU, holds it for a programmable access latency, performs the read or write on a word-addressed storage array, then acknowledges with read data. While a request is outstanding it drives a stall to the CPU so the pipeline freezes until the access completes.

## Interface
- Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in storage; power of two, ≥4
- LATENCY, 4, cycles from request acceptance to ack; integer ≥1
- Ports (one clock; reset is synchronous and active-high):
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- req_i  input  1  request valid; held high by CPU until ack_o
- we_i  input  1  1 = store, 0 = load; sampled at acceptance
- addr_i  input  32  byte address; sampled at acceptance
- wdata_i  input  32  store data; sampled at acceptance
- ready_o  output  1  responder can accept a request this cycle
- stall_o  output  1  combinational; freeze pipeline
- ack_o  output  1  one-cycle completion pulse
- rdata_o  output  32  load data, valid when ack_o and thereafter
- err_o  output  1  misaligned-access flag, valid with ack_o

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: ready_o=1. If req_i: latch we/addr/wdata, load counter with LATENCY-1, go BUSY.
- BUSY: ready_o=0. If counter==0: perform access, go RESP; else decrement counter.
- Access: word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around). Store writes wdata to array, rdata_o unchanged. Load registers array word into rdata_o.
- RESP: ack_o=1 for exactly one cycle, ready_o=0; go IDLE unconditionally. No acceptance in RESP, even if req_i high.
- stall_o = (IDLE & req_i) | BUSY. Low in RESP so the pipeline advances on the ack cycle.
- req_i dropped during BUSY: ignored; access completes and acks anyway.
- rdata_o holds last load value until the next load completes.

## Timing
- Request accepted on edge E0 (IDLE & req_i). ack_o high in the cycle after edge E0+LATENCY. Read data and array write committed at that same edge.
- Minimum turnaround: LATENCY+2 cycles from one acceptance to the next.
- Reset values: state IDLE, counter 0, ready_o 1, ack_o 0, err_o 0, rdata_o 0, stall_o = req_i; array contents cleared to zero.
- Reset mid-operation (BUSY or RESP): access aborted, pending store not written, no ack, return IDLE.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: addr[1:0]≠0 at acceptance marks the request erroneous; no array access, rdata_o forced to 0, err_o=1 concurrent with ack_o. Latency unchanged.
- Not defined: addr[1:0] ignored, access proceeds on the word index, err_o tied 0.

## Structure
- Shared package dmem_pkg: state enum typedef (DMEM_IDLE, DMEM_BUSY, DMEM_RESP) and the latched-request struct (we, addr, wdata).
- One sub-module: dmem_array, single-port synchronous word array (clk_i, rst_i, we, index, wdata, rdata) with synchronous zero-clear on reset.
- Top holds FSM, latency counter, request latch, output registers.

## Test plan
- Reset, then LATENCY=4, store 0xDEADBEEF to 0x10 -> stall_o high 5 cycles including request cycle, ack_o high cycle after E0+4, rdata_o stays 0.
- Load from 0x10 after above -> ack_o after 4-cycle latency, rdata_o=0xDEADBEEF, err_o=0.
- DEPTH_WORDS=256, store 0x1234 to 0x400, load 0x000 -> rdata_o=0x1234 (wrap-around).
- req_i held high continuously for two loads -> no acceptance in RESP; second ack exactly LATENCY+2 cycles after first.
- rst_i asserted during BUSY of store 0xAAAA5555 to 0x20 -> no ack; subsequent load of 0x20 returns 0.
- With DMEM_MISALIGN_ERR_EN, store to 0x22 -> ack_o with err_o=1; load 0x20 returns 0. Without it, same store writes word 0x20.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and latched request payload.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, synchronous zero-clear on reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a programmable access latency and pipeline stall.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    dmem_req_t         req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept_c;
    logic              access_c;
    logic              mis_c;
    logic              arr_we_c;
    logic [IDX_W-1:0]  arr_index;
    logic [DATA_W-1:0] arr_rdata;

    // Address bits above the word index and the byte offset do not select storage.
    logic              unused_addr;
    assign unused_addr = ^req_q.addr;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_c = |req_q.addr[1:0];
`else
    assign mis_c = 1'b0;
`endif

    assign arr_index = req_q.addr[IDX_W+1:2];
    assign arr_we_c  = access_c & req_q.we & ~mis_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: if (req_i) state_d = DMEM_BUSY;
            DMEM_BUSY: if (cnt_q == '0) state_d = DMEM_RESP;
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    // Stall and datapath strobes decoded from the current state
    always_comb begin
        stall_o  = 1'b0;
        accept_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                stall_o  = req_i;
                accept_c = req_i;
            end
            DMEM_BUSY: begin
                stall_o  = 1'b1;
                access_c = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Request latch, latency counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= '0;
            cnt_q   <= '0;
            ready_o <= 1'b1;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ready_o <= (state_d == DMEM_IDLE);
            ack_o   <= (state_d == DMEM_RESP);
            err_o   <= access_c & mis_c;
            if (accept_c) begin
                req_q <= '{we: we_i, addr: addr_i, wdata: wdata_i};
                cnt_q <= CNT_LOAD;
            end else if (state_q == DMEM_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (access_c) begin
                if (mis_c) begin
                    rdata_o <= '0;
                end else if (!req_q.we) begin
                    rdata_o <= arr_rdata;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (arr_we_c),
        .index (arr_index),
        .wdata (req_q.wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver predicts each response from a cycle/array model,
// an independent monitor checks handshake, stall, timing and data every cycle.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [31:0] addr_i  = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o;
    logic        stall_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ready_o (ready_o),
        .stall_o (stall_o),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          e0;
        int          ack;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata = '0;
    logic [31:0] cur_rdata = '0;
    int          next_free = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) tick();
    endtask

    // Issue one request; expected acceptance edge and result come from the model, not the DUT.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit wait_ack = 1'b1);
        exp_t e;
        int   idx;
        logic mis;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        req_i   = 1'b1;
        e.e0  = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        e.ack = e.e0 + int'(LAT);
        idx   = int'((a >> 2) % DEPTH);
        mis   = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (a[1:0] != 2'b00);
`endif
        e.err = mis;
        if (mis) ref_rdata = '0;
        else if (w) ref_mem[idx] = d;
        else ref_rdata = ref_mem[idx];
        e.rdata = ref_rdata;
        q.push_back(e);
        next_free = e.ack + 2;
        if (wait_ack) begin
            while (cyc < e.ack) tick();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        q.delete();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_rdata = '0;
        cur_rdata = '0;
        next_free = 0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_ack",   32'(ack_o),   32'd0);
        check("rst_err",   32'(err_o),   32'd0);
        check("rst_rdata", rdata_o,      32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
    endtask

    // Monitor: classify each cycle against the oldest outstanding prediction.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (q.size() > 0 && cyc == q[0].ack) begin
                check("ack",        32'(ack_o),   32'd1);
                check("rdata_ack",  rdata_o,      q[0].rdata);
                check("err_ack",    32'(err_o),   32'(q[0].err));
                check("ready_resp", 32'(ready_o), 32'd0);
                check("stall_resp", 32'(stall_o), 32'd0);
                cur_rdata = q[0].rdata;
                void'(q.pop_front());
            end else if (q.size() > 0 && cyc >= q[0].e0) begin
                check("ready_busy", 32'(ready_o), 32'd0);
                check("stall_busy", 32'(stall_o), 32'd1);
                check("ack_busy",   32'(ack_o),   32'd0);
                check("rdata_hold", rdata_o,      cur_rdata);
            end else begin
                check("ready_idle", 32'(ready_o), 32'd1);
                check("stall_idle", 32'(stall_o), 32'(req_i));
                check("ack_idle",   32'(ack_o),   32'd0);
                check("err_idle",   32'(err_o),   32'd0);
                check("rdata_idle", rdata_o,      cur_rdata);
            end
        end
    end

    initial begin
        logic [31:0] a;
        do_reset();

        issue(1'b1, 32'h10, 32'hDEAD_BEEF);
        idle(1);
        issue(1'b0, 32'h10, 32'h0);
        idle(2);

        // Aliasing: 0x400 maps onto word 0 in a 256-word array
        issue(1'b1, 32'h400, 32'h0000_1234);
        idle(1);
        issue(1'b0, 32'h000, 32'h0);

        // Back-to-back loads with req held high across the ack cycle
        issue(1'b0, 32'h10, 32'h0);
        issue(1'b0, 32'h400, 32'h0);
        idle(1);

        // Reset during BUSY aborts the store and clears storage
        issue(1'b1, 32'h20, 32'hAAAA_5555, 1'b0);
        tick();
        tick();
        do_reset();
        issue(1'b0, 32'h20, 32'h0);
        idle(1);

        issue(1'b1, 32'h22, 32'hCAFE_F00D);
        idle(1);
        issue(1'b0, 32'h20, 32'h0);
        idle(1);

        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 31)) << 2;
            a = a | (32'($urandom_range(0, 3)) << 10);
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            issue(1'($urandom_range(0, 1)), a, $urandom());
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end

        idle(int'(LAT) + 3);
        check("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
